// File: rtl/dmac_rr_encoder.sv
// Round-robin arbiter and 8-to-3 encoder for DMAC channel requests.
// Holds one registered grant (index + one-hot) until the DMA engine signals done.
module dmac_rr_encoder #(
    parameter int N_CH  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_CH-1:0]  gnt_onehot,
    output logic [7:0]       busy_cnt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_CH-1:0]  oh_q, oh_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;

    // Search from ptr upward; the IDX_W-bit add wraps N_CH-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    oh_d    = N_CH'(1) << win_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done) begin
                    state_d = IDLE;
                    oh_d    = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_valid  = (state_q == GRANT);
    assign gnt_idx    = idx_q;
    assign gnt_onehot = oh_q;
    assign busy_cnt   = cnt_q;

endmodule

// File: tb/tb_dmac_rr_encoder.sv
// Directed bench for dmac_rr_encoder: arbitration order, hold, wrap,
// withdrawal, mid-grant reset and busy counter saturation.
module tb_dmac_rr_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic [7:0] busy_cnt;

    int checks = 0;
    int errors = 0;

    dmac_rr_encoder #(.N_CH(8), .IDX_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_onehot(gnt_onehot),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [2:0] idx);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
        check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, "_onehot"}, 32'(gnt_onehot), 32'(8'd1 << idx));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_onehot"}, 32'(gnt_onehot), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_idle("rst");
        check("rst_idx", 32'(gnt_idx), 32'd0);
        check("rst_cnt", 32'(busy_cnt), 32'd0);

        for (int i = 0; i < 10; i++) begin
            step();
            check_idle("noreq");
            check("noreq_idx", 32'(gnt_idx), 32'd0);
        end

        done = 1'b1;
        step();
        done = 1'b0;
        check_idle("done_in_idle");

        // single request on channel 5, held 6 cycles
        req = 8'b0010_0000;
        step();
        check_grant("ch5", 3'd5);
        check("ch5_cnt0", 32'(busy_cnt), 32'd0);
        for (int i = 0; i < 6; i++) step();
        check_grant("ch5_hold", 3'd5);
        check("ch5_cnt6", 32'(busy_cnt), 32'd6);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
        check_idle("ch5_done");
        check("ch5_idx_kept", 32'(gnt_idx), 32'd5);

        // all channels requesting: rotate 0..7,0 from ptr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            check_grant($sformatf("rot%0d", k), 3'(k % 8));
            done = 1'b1;
            step();
            done = 1'b0;
            check_idle($sformatf("rot%0d_gap", k));
            step();
        end
        // grant to 1 now held; release it, ptr -> 2
        check_grant("rot_tail", 3'd1);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;

        // serve channel 6 so ptr lands on 7, then wrap to 0
        req = 8'b0100_0000;
        step();
        check_grant("pre_wrap", 3'd6);
        done = 1'b1;
        req  = 8'b0000_0011;
        step();
        done = 1'b0;
        check_idle("wrap_gap");
        step();
        check_grant("wrap", 3'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_idle("wrap_gap2");
        step();
        check_grant("after_wrap", 3'd1);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;

        // request withdrawal during grant to channel 2
        req = 8'b0000_0100;
        step();
        check_grant("wd", 3'd2);
        req = 8'b0001_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant($sformatf("wd_hold%0d", i), 3'd2);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        check_idle("wd_gap");
        step();
        check_grant("wd_next", 3'd4);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;

        // reset in the middle of a grant to channel 6
        req = 8'b0100_0000;
        step();
        check_grant("mid", 3'd6);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("mid_rst");
        check("mid_rst_idx", 32'(gnt_idx), 32'd0);
        check("mid_rst_cnt", 32'(busy_cnt), 32'd0);
        req = 8'b1100_0001;
        step();
        check_grant("post_rst", 3'd0);

        // long hold without done: counter saturates
        for (int i = 0; i < 254; i++) step();
        check("cnt254", 32'(busy_cnt), 32'd254);
        step();
        check("cnt255", 32'(busy_cnt), 32'd255);
        for (int i = 0; i < 45; i++) step();
        check("cnt_sat", 32'(busy_cnt), 32'd255);
        check_grant("long", 3'd0);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
        check_idle("long_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
